// File: rtl/ingress_frame_writer_if.sv
// Ingress stream, frame FIFO write port and sideband FIFO write port of the frame writer.
// master = the frame writer itself; slave = the stream source plus the two FIFOs around it.
interface ingress_frame_writer_if #(
    parameter int CURSOR_W = 12
);
    logic                s_tvalid;
    logic [15:0]         s_tdata;
    logic                s_tlast;
    logic                s_tuser;
    logic                s_tready;

    logic                frame_wen;
    logic [19:0]         frame_wdata;
    logic                frame_full;
    logic [CURSOR_W-1:0] frame_wptr;
    logic                frame_wrst;
    logic [CURSOR_W-1:0] frame_rst_wptr;

    logic                sb_wen;
    logic [19:0]         sb_wdata;
    logic                sb_full;

    modport master (
        input  s_tvalid, s_tdata, s_tlast, s_tuser,
        input  frame_full, frame_wptr, sb_full,
        output s_tready, frame_wen, frame_wdata, frame_wrst, frame_rst_wptr,
        output sb_wen, sb_wdata
    );

    modport slave (
        output s_tvalid, s_tdata, s_tlast, s_tuser,
        output frame_full, frame_wptr, sb_full,
        input  s_tready, frame_wen, frame_wdata, frame_wrst, frame_rst_wptr,
        input  sb_wen, sb_wdata
    );
endinterface

// File: rtl/ingress_frame_writer.sv
// Writes ingress frames into the frame FIFO, commits good frames through the sideband FIFO
// and erases bad ones by rewinding the frame FIFO write cursor to the frame's start.
module ingress_frame_writer #(
    parameter int CURSOR_W        = 12,
    parameter int MAX_FRAME_WORDS = 759,
    parameter int MIN_FRAME_WORDS = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    ingress_frame_writer_if.master      bus,
    output logic [15:0]                 frames_ok,
    output logic [15:0]                 frames_dropped
);
    typedef enum logic [2:0] {
        IDLE,
        RECV,
        DROP,
        COMMIT,
        REWIND
    } state_t;

    localparam logic [11:0] MAX_LEN = 12'(MAX_FRAME_WORDS);
    localparam logic [12:0] MIN_LEN = 13'(MIN_FRAME_WORDS);

    state_t              state_reg, state_next;
    logic [CURSOR_W-1:0] start_ptr_reg, start_ptr_next;
    logic [11:0]         len_reg, len_next;
    logic [15:0]         frames_ok_reg, frames_dropped_reg;
    logic                frame_wrst_reg, sb_wen_reg;
    logic [CURSOR_W-1:0] frame_rst_wptr_reg;
    logic [19:0]         sb_wdata_reg;

    logic                ready;
    logic                wr_ok;
    logic                beat;
    logic [12:0]         len_plus1;

    assign len_plus1 = {1'b0, len_reg} + 13'd1;

    // en is only consulted in IDLE, so a frame already admitted always runs to its tlast.
    always_comb begin
        ready = 1'b0;
        wr_ok = 1'b0;
        case (state_reg)
            IDLE: begin
                ready = en & ~bus.sb_full;
                wr_ok = ~bus.frame_full;
            end
            RECV: begin
                ready = 1'b1;
                wr_ok = ~bus.frame_full & (len_reg < MAX_LEN);
            end
            DROP:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
        if (reset) begin
            ready = 1'b0;
        end
    end

    assign beat            = bus.s_tvalid & ready;
    assign bus.s_tready    = ready;
    assign bus.frame_wen   = beat & wr_ok;
    assign bus.frame_wdata = {4'b0, bus.s_tdata};

    always_comb begin
        state_next     = state_reg;
        start_ptr_next = start_ptr_reg;
        len_next       = len_reg;
        case (state_reg)
            IDLE: begin
                if (beat) begin
                    start_ptr_next = bus.frame_wptr;
                    len_next       = bus.frame_full ? 12'd0 : 12'd1;
                    if (bus.s_tlast) begin
                        state_next = REWIND;
                    end else if (bus.frame_full) begin
                        state_next = DROP;
                    end else begin
                        state_next = RECV;
                    end
                end
            end
            RECV: begin
                if (beat) begin
                    if (wr_ok) begin
                        len_next = (len_reg == 12'hFFF) ? len_reg : len_reg + 12'd1;
                        if (bus.s_tlast) begin
                            state_next = (~bus.s_tuser && (len_plus1 >= MIN_LEN)) ? COMMIT : REWIND;
                        end
                    end else begin
                        // Overflow or full FIFO: the frame is already lost, s_tuser adds nothing.
                        state_next = bus.s_tlast ? REWIND : DROP;
                    end
                end
            end
            DROP: begin
                if (beat && bus.s_tlast) begin
                    state_next = REWIND;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= IDLE;
            start_ptr_reg      <= '0;
            len_reg            <= '0;
            frame_wrst_reg     <= 1'b0;
            frame_rst_wptr_reg <= '0;
            sb_wen_reg         <= 1'b0;
            sb_wdata_reg       <= '0;
            frames_ok_reg      <= '0;
            frames_dropped_reg <= '0;
        end else begin
            state_reg          <= state_next;
            start_ptr_reg      <= start_ptr_next;
            len_reg            <= len_next;
            // Decoded from the next state so they are flop outputs during COMMIT/REWIND.
            frame_wrst_reg     <= (state_next == REWIND);
            frame_rst_wptr_reg <= (state_next == REWIND) ? start_ptr_next : '0;
            sb_wen_reg         <= (state_next == COMMIT);
            sb_wdata_reg       <= (state_next == COMMIT) ? {8'b0, len_next} : 20'd0;
            if (state_reg == COMMIT && frames_ok_reg != 16'hFFFF) begin
                frames_ok_reg <= frames_ok_reg + 16'd1;
            end
            if (state_reg == REWIND && frames_dropped_reg != 16'hFFFF) begin
                frames_dropped_reg <= frames_dropped_reg + 16'd1;
            end
        end
    end

    assign bus.frame_wrst     = frame_wrst_reg;
    assign bus.frame_rst_wptr = frame_rst_wptr_reg;
    assign bus.sb_wen         = sb_wen_reg;
    assign bus.sb_wdata       = sb_wdata_reg;
    assign frames_ok          = frames_ok_reg;
    assign frames_dropped     = frames_dropped_reg;
endmodule

// File: tb/tb_ingress_frame_writer.sv
// Directed bench for ingress_frame_writer: scoreboards frame words, sideband commits
// and rewinds, and checks handshake timing and counters around each frame.
module tb_ingress_frame_writer;
    localparam int CW = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [15:0] frames_ok;
    logic [15:0] frames_dropped;

    always #5 clk = ~clk;

    ingress_frame_writer_if #(.CURSOR_W(CW)) bus ();

    ingress_frame_writer #(
        .CURSOR_W        (CW),
        .MAX_FRAME_WORDS (759),
        .MIN_FRAME_WORDS (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .bus            (bus),
        .frames_ok      (frames_ok),
        .frames_dropped (frames_dropped)
    );

    // Frame FIFO write cursor as the FIFO itself would keep it.
    logic [CW-1:0] wptr;
    always @(posedge clk) begin
        if (reset)               wptr <= '0;
        else if (bus.frame_wrst) wptr <= bus.frame_rst_wptr;
        else if (bus.frame_wen)  wptr <= wptr + 1'b1;
    end
    assign bus.frame_wptr = wptr;

    logic [19:0]   exp_wdata_q[$];
    logic [19:0]   exp_sb_q[$];
    logic [CW-1:0] exp_rst_q[$];
    int            compared   = 0;
    int            mismatched = 0;
    logic [15:0]   exp_ok;
    logic [15:0]   exp_drop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.frame_wen) begin
                check("wen_expected", 32'(exp_wdata_q.size() != 0), 1);
                if (exp_wdata_q.size() != 0) check("frame_wdata", bus.frame_wdata, exp_wdata_q.pop_front());
            end
            if (bus.sb_wen) begin
                check("sb_expected", 32'(exp_sb_q.size() != 0), 1);
                if (exp_sb_q.size() != 0) check("sb_wdata", bus.sb_wdata, exp_sb_q.pop_front());
            end
            if (bus.frame_wrst) begin
                check("wrst_expected", 32'(exp_rst_q.size() != 0), 1);
                if (exp_rst_q.size() != 0) check("frame_rst_wptr", bus.frame_rst_wptr, exp_rst_q.pop_front());
            end
        end
    end

    // Drives one frame; entered and left at posedge+1. full_at < 0 means frame_full never rises.
    task automatic send_frame(input int n, input bit tuser, input int full_at, input bit en_low_mid);
        int            written = 0;
        bit            bad = 1'b0;
        bit            good;
        int            k;
        logic [15:0]   d;
        logic [CW-1:0] start = '0;
        for (int i = 0; i < n; i++) begin
            d              = 16'($urandom);
            bus.s_tvalid   = 1'b1;
            bus.s_tdata    = d;
            bus.s_tlast    = (i == n - 1);
            bus.s_tuser    = tuser && (i == n - 1);
            bus.frame_full = (full_at >= 0) && (i >= full_at);
            #1;
            k = 0;
            while (!bus.s_tready && k < 100) begin
                @(posedge clk);
                #2;
                k++;
            end
            if (!bus.s_tready) begin
                check("tready_timeout", bus.s_tready, 1);
                $fatal(1, "ingress handshake stalled");
            end
            if (i == 0) start = wptr;
            if (!bad && !bus.frame_full && written < 759) begin
                exp_wdata_q.push_back({4'b0, d});
                written++;
            end else begin
                bad = 1'b1;
            end
            @(posedge clk);
            #1;
            if (en_low_mid && i == 0) en = 1'b0;
        end
        bus.s_tvalid   = 1'b0;
        bus.s_tlast    = 1'b0;
        bus.s_tuser    = 1'b0;
        bus.frame_full = 1'b0;
        good = !bad && !tuser && (written >= 32);
        if (good) begin
            exp_sb_q.push_back(20'(written));
            if (exp_ok != 16'hFFFF) exp_ok++;
        end else begin
            exp_rst_q.push_back(start);
            if (exp_drop != 16'hFFFF) exp_drop++;
        end
        #1;
        check("tready_gap", bus.s_tready, 0);
        check("commit_cycle", bus.sb_wen, good);
        check("rewind_cycle", bus.frame_wrst, !good);
        @(posedge clk);
        #2;
        check("tready_back", bus.s_tready, en & ~bus.sb_full);
        check("frames_ok", frames_ok, exp_ok);
        check("frames_dropped", frames_dropped, exp_drop);
        check("frame_wen_idle", bus.frame_wen, 0);
        en = 1'b1;
        cyc(1);
    endtask

    initial begin
        logic [15:0] d;
        reset          = 1'b1;
        en             = 1'b1;
        exp_ok         = '0;
        exp_drop       = '0;
        bus.s_tvalid   = 1'b0;
        bus.s_tdata    = '0;
        bus.s_tlast    = 1'b0;
        bus.s_tuser    = 1'b0;
        bus.frame_full = 1'b0;
        bus.sb_full    = 1'b0;

        @(posedge clk);
        #2;
        check("reset_tready", bus.s_tready, 0);
        check("reset_wrst", bus.frame_wrst, 0);
        check("reset_sb_wen", bus.sb_wen, 0);
        check("reset_ok", frames_ok, 0);
        check("reset_drop", frames_dropped, 0);
        cyc(1);
        reset = 1'b0;
        #1;
        check("idle_tready", bus.s_tready, 1);
        cyc(1);

        send_frame(32, 1'b0, -1, 1'b0);   // minimum good frame
        send_frame(40, 1'b0, -1, 1'b1);   // en dropped after admission
        send_frame(20, 1'b0, -1, 1'b0);   // runt
        send_frame(759, 1'b0, -1, 1'b0);  // maximum good frame
        send_frame(800, 1'b0, -1, 1'b0);  // oversize
        send_frame(100, 1'b1, -1, 1'b0);  // tuser error
        send_frame(50, 1'b0, -1, 1'b0);   // resumes at restored cursor

        bus.sb_full = 1'b1;
        bus.s_tvalid = 1'b1;
        cyc(2);
        #1;
        check("sb_full_tready", bus.s_tready, 0);
        check("sb_full_no_wen", bus.frame_wen, 0);
        bus.s_tvalid = 1'b0;
        bus.sb_full = 1'b0;
        cyc(1);
        send_frame(35, 1'b0, -1, 1'b0);

        send_frame(40, 1'b0, 9, 1'b0);    // frame_full from word 10
        send_frame(40, 1'b0, 39, 1'b0);   // frame_full on the tlast beat
        send_frame(3, 1'b0, 0, 1'b0);     // frame_full on the first beat

        en = 1'b0;
        #1;
        check("en_low_tready", bus.s_tready, 0);
        en = 1'b1;
        cyc(1);

        for (int i = 0; i < 5; i++) begin
            d = 16'($urandom);
            bus.s_tvalid = 1'b1;
            bus.s_tdata  = d;
            #1;
            check("midframe_tready", bus.s_tready, 1);
            exp_wdata_q.push_back({4'b0, d});
            cyc(1);
        end
        reset = 1'b1;
        #1;
        check("reset_mid_tready", bus.s_tready, 0);
        check("reset_mid_wen", bus.frame_wen, 0);
        cyc(1);
        #1;
        check("reset_mid_wrst", bus.frame_wrst, 0);
        check("reset_mid_rst_wptr", bus.frame_rst_wptr, 0);
        check("reset_mid_sb_wen", bus.sb_wen, 0);
        check("reset_mid_sb_wdata", bus.sb_wdata, 0);
        check("reset_mid_ok", frames_ok, 0);
        check("reset_mid_drop", frames_dropped, 0);
        bus.s_tvalid = 1'b0;
        exp_ok   = '0;
        exp_drop = '0;
        cyc(1);
        reset = 1'b0;
        #1;
        check("after_reset_tready", bus.s_tready, 1);
        cyc(1);
        send_frame(33, 1'b0, -1, 1'b0);

        force dut.frames_dropped_reg = 16'hFFFE;
        #1;
        release dut.frames_dropped_reg;
        exp_drop = 16'hFFFE;
        cyc(1);
        send_frame(1, 1'b0, -1, 1'b0);
        send_frame(1, 1'b0, -1, 1'b0);
        send_frame(1, 1'b0, -1, 1'b0);

        cyc(3);
        check("wdata_q_left", exp_wdata_q.size(), 0);
        check("sb_q_left", exp_sb_q.size(), 0);
        check("rst_q_left", exp_rst_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
